// File: rtl/muldiv_ctrl_pkg.sv
// Shared opcode/state encodings and default sizing for the HI/LO multiply-divide unit.
package muldiv_ctrl_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline <-> mul/div unit bus: launch, MTHI/MTLO writes, status and HI/LO readback.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi_we, mtlo_we, mt_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi_we, mtlo_we, mt_data,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_ctrl_step.sv
// One iteration of the shared datapath: right-shift shift-add multiply or left-shift restoring divide.
// acc layout: acc[2W:W] is the running high part / partial remainder, acc[W-1:0] the multiplier / quotient.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] opnd,
    input  logic             is_div,
    output logic [2*WIDTH:0] acc_next,
    output logic             q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_rem;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum      = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
        shl_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = {1'b0, shl_rem} - {2'b00, opnd};
        q_bit    = is_div & ~diff[WIDTH+1];
        acc_next = '0;
        // Quotient bit is left as 0 here; the caller merges q_bit into bit 0.
        if (is_div)
            acc_next = {(q_bit ? diff[WIDTH:0] : shl_rem), acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {1'b0, (acc[0] ? sum : acc[2*WIDTH:WIDTH]), acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: latch magnitudes, WIDTH iterations, then sign fixup.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    muldiv_ctrl_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q, neg_q_q, neg_r_q, divz_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH:0]   acc_q, acc_nxt;
    logic               q_bit;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dz_q;

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Two's-complement magnitude of 0x80..0 is itself, read as unsigned 2^(W-1).
    always_comb begin
        sgn_a = ~bus.op[0] & bus.a[WIDTH-1];
        sgn_b = ~bus.op[0] & bus.b[WIDTH-1];
        mag_a = sgn_a ? -bus.a : bus.a;
        mag_b = sgn_b ? -bus.b : bus.b;
    end

    always_comb begin
        prod_fix = neg_q_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo_fix  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .opnd     (opnd_q),
        .is_div   (is_div_q),
        .acc_next (acc_nxt),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            divz_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.mthi_we) hi_q <= bus.mt_data;
                    if (bus.mtlo_we) lo_q <= bus.mt_data;
                    if (bus.start) begin
                        is_div_q <= bus.op[1];
                        neg_q_q  <= sgn_a ^ sgn_b;
                        neg_r_q  <= sgn_a;
                        divz_q   <= bus.op[1] & (bus.b == '0);
                        cnt_q    <= '0;
                        opnd_q   <= bus.op[1] ? mag_b : mag_a;
                        acc_q    <= {{(WIDTH+1){1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                    end
                end
                CALC: begin
                    acc_q <= {acc_nxt[2*WIDTH:1], acc_nxt[0] | q_bit};
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    done_q <= 1'b1;
                    dz_q   <= divz_q;
                    // Divide by zero leaves remainder = |a|, so rem_fix restores a exactly.
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= divz_q ? '1 : quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: countdown/arithmetic reference model checked every cycle plus literal pins.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    muldiv_ctrl_if #(.WIDTH(W)) bus();

    muldiv_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic (SV / and % truncate toward zero).
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin q = sa * sb; return 64'(q); end
            2'b01: begin p = ua * ub; return 64'(p); end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Model: an operation accepted in idle commits 33 edges later; nothing else is accepted meanwhile.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz;
                end
            end else begin
                if (bus.mthi_we) m_hi = bus.mt_data;
                if (bus.mtlo_we) m_lo = bus.mt_data;
                if (bus.start) begin
                    {p_hi, p_lo} = ref_res(bus.op, bus.a, bus.b);
                    p_dz   = bus.op[1] && (bus.b == 0);
                    m_left = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     64'(bus.busy),     64'(m_left > 0));
            chk("done",     64'(bus.done),     64'(m_done));
            chk("div_zero", 64'(bus.div_zero), 64'(m_dz));
            chk("hi",       64'(bus.hi),       64'(m_hi));
            chk("lo",       64'(bus.lo),       64'(m_lo));
        end
    end

    // Called at posedge+1 in idle; returns at posedge+1 of the done cycle (or after the bound).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
        busy_n = int'(bus.busy);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
            busy_n += int'(bus.busy);
        end
    endtask

    task automatic run_chk(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
        int lat, busy_n;
        issue(op, a, b, lat, busy_n);
        chk({name, " latency"}, 64'(lat), 64'd33);
        chk({name, " busy cycles"}, 64'(busy_n), 64'd33);
        chk({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
        chk({name, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0; bus.mt_data = '0;

        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset busy",     64'(bus.busy),     64'd0);
        chk("reset done",     64'(bus.done),     64'd0);
        chk("reset div_zero", 64'(bus.div_zero), 64'd0);
        chk("reset hi",       64'(bus.hi),       64'd0);
        chk("reset lo",       64'(bus.lo),       64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_chk("multu max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_chk("mult -3*7",   2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_chk("mult min^2",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_chk("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_chk("divu 100/7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run_chk("div ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_chk("divu 5/0",    2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        chk("div_zero single cycle", 64'(bus.div_zero), 64'd0);
        run_chk("div -9/0",    2'b10, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        run_chk("multu 3*4 (before reset)", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        // MTHI alone, then MTHI+MTLO together.
        bus.mthi_we = 1'b1; bus.mt_data = 32'h0000_1234;
        @(posedge clk); #1 bus.mthi_we = 1'b0;
        chk("mthi hi", 64'(bus.hi), 64'h1234);
        chk("mthi lo kept", 64'(bus.lo), 64'd12);
        bus.mthi_we = 1'b1; bus.mtlo_we = 1'b1; bus.mt_data = 32'hA5A5_0001;
        @(posedge clk); #1 bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0;
        chk("mt both hi", 64'(bus.hi), 64'hA5A5_0001);
        chk("mt both lo", 64'(bus.lo), 64'hA5A5_0001);

        // Async reset at counter = 10 clears everything and aborts the operation.
        bus.op = 2'b01; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort hi",   64'(bus.hi),   64'd0);
        chk("abort lo",   64'(bus.lo),   64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) n++;
        end
        chk("abort no done", 64'(n), 64'd0);
        run_chk("multu 3*4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        // start + MTHI ten cycles into CALC are both dropped.
        bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd1;
        bus.mthi_we = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi_we = 1'b0;
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy ignore done seen", 64'(bus.done), 64'd1);
        chk("busy ignore hi", 64'(bus.hi), 64'd0);
        chk("busy ignore lo", 64'(bus.lo), 64'd42);
        repeat (3) @(posedge clk);
        #1;
        chk("busy ignore no queue", 64'(bus.busy), 64'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for MULT, MULTU, DIV and DIVU in the 54-instruction CPU.
- Owns the HI and LO registers and one shared iterative shift-add / restoring-subtract datapath.
- Zero-extends or sign-handles operands according to the opcode.
- Drives busy so the pipeline stalls MFHI, MFLO and new mul/div instructions until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch an operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- mthi_we  in  1  write mt_data to HI (MTHI)
- mtlo_we  in  1  write mt_data to LO (MTLO)
- mt_data  in  WIDTH  MTHI/MTLO data
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse when HI/LO are committed
- div_zero  out  1  pulses with done when a DIV/DIVU had b == 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n = 0): state = IDLE, counter = 0, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, all internal operand registers = 0.
  - Reset asserted mid-operation aborts the operation immediately; no partial result reaches HI/LO.
- State machine:
  - IDLE -> CALC on start.
  - CALC -> FIX when counter = WIDTH-1.
  - FIX -> IDLE unconditionally.
- Edge E0 (start sampled high in IDLE):
  - Latch op, sign flags and magnitudes; counter = 0.
  - Signed ops (MULT, DIV) use the two's-complement magnitude of a negative operand. Unsigned ops use a and b zero-extended.
  - 0x80000000 has magnitude 2^31, so the internal datapath is WIDTH+1 bits.
- CALC: one iteration per clock, WIDTH iterations (edges E1..E32).
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX, edge E33:
  - Apply sign correction:
    - product negated if sign(a) XOR sign(b);
    - quotient negated if sign(a) XOR sign(b);
    - remainder takes the sign of a.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - done = 1 (registered) for exactly the cycle after E33.
- Latency: start-edge E0 to done visible = 33 cycles. busy is high for the cycles after E0 through E33 inclusive.
- Divide by zero: same latency. HI = a (unmodified), LO = all ones, div_zero pulses with done.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0. This is the natural wrap; no special flag.
- start while busy: ignored, no queueing.
- mthi_we / mtlo_we while busy: ignored.
- mthi_we / mtlo_we in IDLE: HI / LO updated at the next edge. Both may be asserted together.
- start and mthi_we/mtlo_we in the same IDLE cycle: the MT write commits now, and the operation result overwrites it at E33.
- op and operands are sampled only at E0; later changes on a, b and op have no effect.

Decomposition:
- Shared package: opcode constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding (IDLE, CALC, FIX), WIDTH default.
- One natural sub-module, muldiv_step: combinational single iteration that takes the accumulator, operand and mode and returns the next accumulator and quotient bit.
- The FSM, counter, sign fixup and HI/LO registers stay in muldiv_ctrl.

Test Plan:
- MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; done exactly 33 cycles after the start edge; busy high for those cycles only.
- MULT a = 0xFFFFFFFD (-3), b = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB (-21). MULT 0x80000000 * 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV a = -7, b = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2. DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- DIVU a = 5, b = 0 -> HI = 5, LO = 0xFFFFFFFF, div_zero and done high in the same single cycle.
- MTHI 0x1234 in IDLE -> HI = 0x1234 next cycle. start pulse and mthi_we at cycle 10 of CALC -> both ignored; HI/LO hold the first result.
- rst_n pulsed low at counter = 10 -> busy, hi and lo are 0 immediately (asynchronously) and done never fires. Then MULTU 3 * 4 -> LO = 12, HI = 0 with normal latency.
